// File: rtl/bus_sequencer_pkg.sv
// Shared types and lane helpers for the CPU-to-system-bus sequencer.
package bus_sequencer_pkg;

  typedef enum logic [1:0] {
    CW_NULL = 2'b00,
    CW_BYTE = 2'b01,
    CW_WORD = 2'b10,
    CW_LONG = 2'b11
  } t_cycle_width;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_SECOND = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } t_bus_state;

  localparam logic [3:0]  STROBE_NONE   = 4'b0000;
  localparam logic [3:0]  STROBE_BYTE   = 4'b1000;
  localparam logic [3:0]  STROBE_WORD   = 4'b1100;
  localparam logic [3:0]  STROBE_LONG   = 4'b1111;
  localparam logic [31:0] BUS_IDLE_DATA = 32'hffff_ffff;

  function automatic logic [3:0] size_mask(input t_cycle_width width);
    case (width)
      CW_BYTE: size_mask = STROBE_BYTE;
      CW_WORD: size_mask = STROBE_WORD;
      CW_LONG: size_mask = STROBE_LONG;
      default: size_mask = STROBE_NONE;
    endcase
  endfunction

  // Lanes without a strobe float high so an idle lane always reads as 8'hff.
  function automatic logic [31:0] fill_lanes(input logic [31:0] data, input logic [3:0] strobes);
    for (int i = 0; i < 4; i++) begin
      fill_lanes[8*i +: 8] = strobes[i] ? data[8*i +: 8] : 8'hff;
    end
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// CPU-side and system-bus-side signals of the sequencer; master is the sequencer itself.
interface bus_sequencer_if
  import bus_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] cpu_address;
  t_cycle_width          cpu_cycle_width;
  logic [31:0]           cpu_data_out;
  logic [31:0]           cpu_data_in;
  logic                  cpu_read;
  logic                  cpu_write;
  logic                  cpu_ready;

  logic [ADDR_WIDTH-3:0] businterface_address;
  logic [31:0]           businterface_data_in;
  logic [31:0]           businterface_data_out;
  logic [3:0]            businterface_data_strobes;
  logic                  businterface_read;
  logic                  businterface_write;
  logic                  businterface_ack;
  logic                  businterface_error;

  modport master (
    input  cpu_address, cpu_cycle_width, cpu_data_out, cpu_read, cpu_write,
    input  businterface_data_in, businterface_ack,
    output cpu_data_in, cpu_ready,
    output businterface_address, businterface_data_out, businterface_data_strobes,
    output businterface_read, businterface_write, businterface_error
  );

  modport slave (
    output cpu_address, cpu_cycle_width, cpu_data_out, cpu_read, cpu_write,
    output businterface_data_in, businterface_ack,
    input  cpu_data_in, cpu_ready,
    input  businterface_address, businterface_data_out, businterface_data_strobes,
    input  businterface_read, businterface_write, businterface_error
  );

endinterface

// File: rtl/bus_sequencer_lane_mapper.sv
// Combinational byte-lane mapper: strobes/write data per bus cycle and read reassembly.
// Build option MISALIGNED_EN: accept misaligned word/long accesses, split across two cycles.
module bus_sequencer_lane_mapper
  import bus_sequencer_pkg::*;
(
  input  t_cycle_width req_width,
  input  logic [1:0]   req_offset,
  input  logic [31:0]  req_wdata,
  output logic [3:0]   first_strobes,
  output logic [3:0]   second_strobes,
  output logic [31:0]  first_wdata,
  output logic [31:0]  second_wdata,
  output logic         split,
  output logic         legal,
  input  t_cycle_width rd_width,
  input  logic [1:0]   rd_offset,
  input  logic [31:0]  rd_first,
  input  logic [31:8]  rd_second,
  output logic [31:0]  rd_data
);

  logic [7:0]  mask_span_s;
  logic [31:0] wdata_left_s;
  logic [63:0] wdata_span_s;
  logic [31:0] rd_left_s;

  // Request side: left-justify, then shift mask and data right by the byte offset.
  always_comb begin
    mask_span_s = {size_mask(req_width), 4'b0000} >> req_offset;
    case (req_width)
      CW_BYTE: wdata_left_s = {req_wdata[7:0], 24'h000000};
      CW_WORD: wdata_left_s = {req_wdata[15:0], 16'h0000};
      CW_LONG: wdata_left_s = req_wdata;
      default: wdata_left_s = 32'h0000_0000;
    endcase
    wdata_span_s   = {wdata_left_s, 32'h0000_0000} >> {req_offset, 3'b000};
    first_strobes  = mask_span_s[7:4];
    second_strobes = mask_span_s[3:0];
    first_wdata    = fill_lanes(wdata_span_s[63:32], first_strobes);
    second_wdata   = fill_lanes(wdata_span_s[31:0], second_strobes);
`ifdef MISALIGNED_EN
    legal = (req_width != CW_NULL);
    split = (second_strobes != STROBE_NONE);
`else
    case (req_width)
      CW_BYTE: legal = 1'b1;
      CW_WORD: legal = (req_offset[0] == 1'b0);
      CW_LONG: legal = (req_offset == 2'b00);
      default: legal = 1'b0;
    endcase
    split = 1'b0;
`endif
  end

  // Read side: glue the two captured words back together and right-justify.
  always_comb begin
    case (rd_offset)
      2'b00:   rd_left_s = rd_first;
      2'b01:   rd_left_s = {rd_first[23:0], rd_second[31:24]};
      2'b10:   rd_left_s = {rd_first[15:0], rd_second[31:16]};
      2'b11:   rd_left_s = {rd_first[7:0], rd_second[31:8]};
      default: rd_left_s = rd_first;
    endcase
    case (rd_width)
      CW_BYTE: rd_data = {24'hff_ffff, rd_left_s[31:24]};
      CW_WORD: rd_data = {16'hffff, rd_left_s[31:16]};
      CW_LONG: rd_data = rd_left_s;
      default: rd_data = BUS_IDLE_DATA;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Multi-cycle CPU bus sequencer: lane mapping, wait states, optional split cycles, watchdog.
// Build option MISALIGNED_EN (in the lane mapper) enables misaligned split accesses.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic              clock,
  input logic              reset,
  bus_sequencer_if.master  bif
);

  localparam int BA_W = ADDR_WIDTH - 2;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : {WD_W{1'b0}};

  t_bus_state       state_r;
  logic [WD_W-1:0]  wd_r;
  t_cycle_width     width_r;
  logic [1:0]       offset_r;
  logic             split_r;
  logic [3:0]       second_strobes_r;
  logic [31:0]      second_wdata_r;
  logic [31:0]      rd_first_r;

  logic [BA_W-1:0]  addr_r;
  logic [3:0]       strobes_r;
  logic [31:0]      data_out_r;
  logic             read_r;
  logic             write_r;
  logic             ready_r;
  logic             error_r;
  logic [31:0]      cpu_data_in_r;

  logic [3:0]       first_strobes_s;
  logic [3:0]       second_strobes_s;
  logic [31:0]      first_wdata_s;
  logic [31:0]      second_wdata_s;
  logic             split_s;
  logic             legal_s;
  logic [31:0]      rd_first_s;
  logic [31:0]      rd_data_s;
  logic             expire_s;

  // The first word is still on the bus when a single-cycle access completes.
  assign rd_first_s = (state_r == ST_FIRST) ? bif.businterface_data_in : rd_first_r;
  assign expire_s   = (TIMEOUT_CYCLES > 0) && (wd_r == WD_LAST);

  bus_sequencer_lane_mapper u_mapper (
    .req_width      (bif.cpu_cycle_width),
    .req_offset     (bif.cpu_address[1:0]),
    .req_wdata      (bif.cpu_data_out),
    .first_strobes  (first_strobes_s),
    .second_strobes (second_strobes_s),
    .first_wdata    (first_wdata_s),
    .second_wdata   (second_wdata_s),
    .split          (split_s),
    .legal          (legal_s),
    .rd_width       (width_r),
    .rd_offset      (offset_r),
    .rd_first       (rd_first_s),
    .rd_second      (bif.businterface_data_in[31:8]),
    .rd_data        (rd_data_s)
  );

  // Sequencer FSM with watchdog; every CPU- and bus-facing output is a register here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      wd_r             <= {WD_W{1'b0}};
      width_r          <= CW_NULL;
      offset_r         <= 2'b00;
      split_r          <= 1'b0;
      second_strobes_r <= STROBE_NONE;
      second_wdata_r   <= BUS_IDLE_DATA;
      rd_first_r       <= BUS_IDLE_DATA;
      addr_r           <= {BA_W{1'b0}};
      strobes_r        <= STROBE_NONE;
      data_out_r       <= BUS_IDLE_DATA;
      read_r           <= 1'b0;
      write_r          <= 1'b0;
      ready_r          <= 1'b0;
      error_r          <= 1'b0;
      cpu_data_in_r    <= BUS_IDLE_DATA;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bif.cpu_read || bif.cpu_write) begin
            if ((bif.cpu_read ^ bif.cpu_write) && legal_s) begin
              addr_r           <= bif.cpu_address[ADDR_WIDTH-1:2];
              strobes_r        <= first_strobes_s;
              data_out_r       <= bif.cpu_write ? first_wdata_s : BUS_IDLE_DATA;
              read_r           <= bif.cpu_read;
              write_r          <= bif.cpu_write;
              width_r          <= bif.cpu_cycle_width;
              offset_r         <= bif.cpu_address[1:0];
              split_r          <= split_s;
              second_strobes_r <= second_strobes_s;
              second_wdata_r   <= bif.cpu_write ? second_wdata_s : BUS_IDLE_DATA;
              wd_r             <= {WD_W{1'b0}};
              state_r          <= ST_FIRST;
            end else begin
              ready_r <= 1'b1;
              error_r <= 1'b1;
              state_r <= ST_FAULT;
            end
          end
        end
        ST_FIRST, ST_SECOND: begin
          // An ack arriving on the expiry edge still completes the cycle.
          if (bif.businterface_ack) begin
            wd_r <= {WD_W{1'b0}};
            if (state_r == ST_FIRST) begin
              rd_first_r <= bif.businterface_data_in;
            end
            if ((state_r == ST_FIRST) && split_r) begin
              addr_r     <= addr_r + BA_W'(1);
              strobes_r  <= second_strobes_r;
              data_out_r <= second_wdata_r;
              state_r    <= ST_SECOND;
            end else begin
              read_r        <= 1'b0;
              write_r       <= 1'b0;
              strobes_r     <= STROBE_NONE;
              data_out_r    <= BUS_IDLE_DATA;
              ready_r       <= 1'b1;
              error_r       <= 1'b0;
              cpu_data_in_r <= read_r ? rd_data_s : BUS_IDLE_DATA;
              state_r       <= ST_DONE;
            end
          end else if (expire_s) begin
            read_r        <= 1'b0;
            write_r       <= 1'b0;
            strobes_r     <= STROBE_NONE;
            data_out_r    <= BUS_IDLE_DATA;
            ready_r       <= 1'b1;
            error_r       <= 1'b1;
            cpu_data_in_r <= BUS_IDLE_DATA;
            state_r       <= ST_FAULT;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        ST_DONE, ST_FAULT: begin
          ready_r       <= 1'b0;
          error_r       <= 1'b0;
          cpu_data_in_r <= BUS_IDLE_DATA;
          state_r       <= ST_IDLE;
        end
        default: begin
          read_r        <= 1'b0;
          write_r       <= 1'b0;
          strobes_r     <= STROBE_NONE;
          data_out_r    <= BUS_IDLE_DATA;
          ready_r       <= 1'b0;
          error_r       <= 1'b0;
          cpu_data_in_r <= BUS_IDLE_DATA;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bif.cpu_ready                 = ready_r;
  assign bif.cpu_data_in               = cpu_data_in_r;
  assign bif.businterface_address      = addr_r;
  assign bif.businterface_data_out     = data_out_r;
  assign bif.businterface_data_strobes = strobes_r;
  assign bif.businterface_read         = read_r;
  assign bif.businterface_write        = write_r;
  assign bif.businterface_error        = error_r;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed table-driven bench for bus_sequencer with a wait-state memory slave model.
module tb_bus_sequencer;
  import bus_sequencer_pkg::*;

  localparam logic [31:0] FF = 32'hffff_ffff;

  logic clock;
  logic reset;

  bus_sequencer_if #(.ADDR_WIDTH(32)) bif ();

  bus_sequencer #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
    .clock (clock),
    .reset (reset),
    .bif   (bif.master)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    t_cycle_width w;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    int           ack_wait;
    logic         err;
    logic [31:0]  rdata;
    int           lat;
    int           qual;
    int           ncyc;
    logic [29:0]  a0;
    logic [3:0]   s0;
    logic [31:0]  d0;
    logic [29:0]  a1;
    logic [3:0]   s1;
    logic [31:0]  d1;
  } vec_t;

  vec_t vecs[11];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_wait = 0;
  int wait_cnt = 0;
  int qual_n   = 0;
  int log_n    = 0;
  logic [29:0] log_a[64];
  logic [3:0]  log_s[64];
  logic [31:0] log_d[64];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'h40:  mem_word = 32'hAABB_CCDD;
      30'h41:  mem_word = 32'hEEFF_0011;
      default: mem_word = {2'b00, a} ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: acks after ack_wait idle cycles, logs every acked bus cycle.
  always @(negedge clock) begin
    if (bif.businterface_ack) wait_cnt = 0;
    bif.businterface_ack = 1'b0;
    if (bif.businterface_read || bif.businterface_write) begin
      qual_n++;
      if (wait_cnt == ack_wait) begin
        bif.businterface_ack     = 1'b1;
        bif.businterface_data_in = mem_word(bif.businterface_address);
        if (log_n < 64) begin
          log_a[log_n] = bif.businterface_address;
          log_s[log_n] = bif.businterface_data_strobes;
          log_d[log_n] = bif.businterface_data_out;
          log_n++;
        end
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, " ready"},   32'(bif.cpu_ready), 32'd0);
    check({tag, " error"},   32'(bif.businterface_error), 32'd0);
    check({tag, " read"},    32'(bif.businterface_read), 32'd0);
    check({tag, " write"},   32'(bif.businterface_write), 32'd0);
    check({tag, " strobes"}, 32'(bif.businterface_data_strobes), 32'd0);
    check({tag, " addr"},    32'(bif.businterface_address), 32'd0);
    check({tag, " dout"},    bif.businterface_data_out, FF);
    check({tag, " din"},     bif.cpu_data_in, FF);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    bit   got;
    int   lbase;
    int   qbase;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clock);
    lbase    = log_n;
    qbase    = qual_n;
    ack_wait = v.ack_wait;
    bif.cpu_address     = v.addr;
    bif.cpu_cycle_width = v.w;
    bif.cpu_data_out    = v.wdata;
    bif.cpu_read        = v.rd;
    bif.cpu_write       = v.wr;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      got = bif.cpu_ready;
    end
    check({p, " ready seen"}, 32'(got), 32'd1);
    check({p, " latency"},    32'(lat), 32'(v.lat));
    check({p, " error"},      32'(bif.businterface_error), 32'(v.err));
    check({p, " rdata"},      bif.cpu_data_in, v.rdata);
    check({p, " strobes idle"}, 32'(bif.businterface_data_strobes), 32'd0);
    check({p, " quals idle"}, 32'(bif.businterface_read | bif.businterface_write), 32'd0);
    check({p, " bus cycles"}, 32'(log_n - lbase), 32'(v.ncyc));
    check({p, " qual cycles"}, 32'(qual_n - qbase), 32'(v.qual));
    for (int c = 0; c < v.ncyc && c < 2 && (lbase + c) < log_n; c++) begin
      check($sformatf("%s c%0d addr", p, c), 32'(log_a[lbase+c]), 32'(c == 0 ? v.a0 : v.a1));
      check($sformatf("%s c%0d strb", p, c), 32'(log_s[lbase+c]), 32'(c == 0 ? v.s0 : v.s1));
      check($sformatf("%s c%0d dout", p, c), log_d[lbase+c], c == 0 ? v.d0 : v.d1);
    end
    bif.cpu_read  = 1'b0;
    bif.cpu_write = 1'b0;
    @(negedge clock);
    check({p, " ready pulse"}, 32'(bif.cpu_ready), 32'd0);
  endtask

  initial begin
    int   guard;
    bit   ready_after;
    logic [29:0] mid_addr;
    logic [31:0] mid_byte;

    reset = 1'b1;
    bif.cpu_address     = 32'h0;
    bif.cpu_cycle_width = CW_NULL;
    bif.cpu_data_out    = 32'h0;
    bif.cpu_read        = 1'b0;
    bif.cpu_write       = 1'b0;

    vecs[0] = '{1'b1, 1'b0, CW_LONG, 32'h100, 32'h0, 0, 1'b0, 32'hAABBCCDD, 2, 1, 1, 30'h40, 4'b1111, FF, 30'h0, 4'b0000, FF};
    vecs[1] = '{1'b0, 1'b1, CW_BYTE, 32'h103, 32'h5A, 4, 1'b0, FF, 6, 5, 1, 30'h40, 4'b0001, 32'hffffff5A, 30'h0, 4'b0000, FF};
`ifdef MISALIGNED_EN
    vecs[2] = '{1'b1, 1'b0, CW_LONG, 32'h102, 32'h0, 0, 1'b0, 32'hCCDDEEFF, 3, 2, 2, 30'h40, 4'b0011, FF, 30'h41, 4'b1100, FF};
    vecs[3] = '{1'b0, 1'b1, CW_LONG, 32'h102, 32'h11223344, 1, 1'b0, FF, 5, 4, 2, 30'h40, 4'b0011, 32'hffff1122, 30'h41, 4'b1100, 32'h3344ffff};
    vecs[5] = '{1'b0, 1'b1, CW_WORD, 32'h201, 32'hBEEF, 0, 1'b0, FF, 2, 1, 1, 30'h80, 4'b0110, 32'hffBEEFff, 30'h0, 4'b0000, FF};
    vecs[9] = '{1'b1, 1'b0, CW_WORD, 32'h103, 32'h0, 0, 1'b0, 32'hffffDDEE, 3, 2, 2, 30'h40, 4'b0001, FF, 30'h41, 4'b1000, FF};
    mid_addr = 30'h41;
    mid_byte = 32'h102;
`else
    vecs[2] = '{1'b1, 1'b0, CW_LONG, 32'h102, 32'h0, 0, 1'b1, FF, 1, 0, 0, 30'h0, 4'b0000, FF, 30'h0, 4'b0000, FF};
    vecs[3] = '{1'b0, 1'b1, CW_LONG, 32'h102, 32'h11223344, 1, 1'b1, FF, 1, 0, 0, 30'h0, 4'b0000, FF, 30'h0, 4'b0000, FF};
    vecs[5] = '{1'b0, 1'b1, CW_WORD, 32'h201, 32'hBEEF, 0, 1'b1, FF, 1, 0, 0, 30'h0, 4'b0000, FF, 30'h0, 4'b0000, FF};
    vecs[9] = '{1'b1, 1'b0, CW_WORD, 32'h103, 32'h0, 0, 1'b1, FF, 1, 0, 0, 30'h0, 4'b0000, FF, 30'h0, 4'b0000, FF};
    mid_addr = 30'h40;
    mid_byte = 32'h100;
`endif
    vecs[4]  = '{1'b1, 1'b0, CW_WORD, 32'h102, 32'h0, 2, 1'b0, 32'hffffCCDD, 4, 3, 1, 30'h40, 4'b0011, FF, 30'h0, 4'b0000, FF};
    vecs[6]  = '{1'b1, 1'b0, CW_BYTE, 32'h101, 32'h0, 0, 1'b0, 32'hffffffBB, 2, 1, 1, 30'h40, 4'b0100, FF, 30'h0, 4'b0000, FF};
    vecs[7]  = '{1'b1, 1'b0, CW_NULL, 32'h100, 32'h0, 0, 1'b1, FF, 1, 0, 0, 30'h0, 4'b0000, FF, 30'h0, 4'b0000, FF};
    vecs[8]  = '{1'b1, 1'b1, CW_LONG, 32'h100, 32'h0, 0, 1'b1, FF, 1, 0, 0, 30'h0, 4'b0000, FF, 30'h0, 4'b0000, FF};
    vecs[10] = '{1'b1, 1'b0, CW_LONG, 32'h300, 32'h0, 1000, 1'b1, FF, 16, 15, 0, 30'h0, 4'b0000, FF, 30'h0, 4'b0000, FF};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of a bus cycle (second cycle of a split when enabled).
    @(negedge clock);
    ack_wait = 5;
    bif.cpu_address     = mid_byte;
    bif.cpu_cycle_width = CW_LONG;
    bif.cpu_read        = 1'b1;
    guard = 0;
    @(negedge clock);
    while (!(bif.businterface_read && bif.businterface_address == mid_addr) && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("midreset reached", 32'(guard < 50), 32'd1);
    reset        = 1'b1;
    bif.cpu_read = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_state("midreset");
    reset = 1'b0;
    ready_after = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (bif.cpu_ready) ready_after = 1'b1;
    end
    check("midreset no ready", 32'(ready_after), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
